// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and a helper
// that sizes the iteration counter for a given width.
package seq_restoring_divider_pkg;

  localparam int unsigned DIV_W = 4;

  // Counter must hold values 0..w, hence clog2(w+1).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_borrow_sub.sv
// Combinational borrow-ripple subtractor: diff_o = a_i - b_i, borrow-in 0.
// Ports:
//   a_i, b_i  N-bit minuend / subtrahend
//   diff_o    N-bit difference (mod 2^N)
//   borrow_o  borrow out of the MSB (1 when a_i < b_i)
module nibble_borrow_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] brw;

  // Full-subtractor chain, LSB first.
  always_comb begin
    brw    = '0;
    diff_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      diff_o[i]  = a_i[i] ^ b_i[i] ^ brw[i];
      brw[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw[i]);
    end
    borrow_o = brw[N];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV_EARLY_EXIT_EN -- when defined, an
// operation with dividend < divisor (divisor != 0) skips RUN entirely.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     W-bit unsigned dividend, captured on accepted start
//   divisor      W-bit unsigned divisor, captured on accepted start
//   busy         high while in RUN
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered W-bit quotient
//   remainder    registered W-bit remainder
//   div_by_zero  registered flag, set with done when divisor was 0
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W:0]      r_q, r_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [W:0]      r_sh;
  logic [W-1:0]    q_sh;
  logic [W:0]      trial;
  logic            borrow;
  logic            unused_rtop;

  // {R,Q} shifted left by one. R's MSB is always 0 between iterations
  // (a restored or accepted R is below the divisor), so it drops out.
  assign r_sh        = {r_q[W-1:0], q_q[W-1]};
  assign q_sh        = q_q << 1;
  assign unused_rtop = r_q[W];

  nibble_borrow_sub #(
    .N(W + 1)
  ) u_sub (
    .a_i     (r_sh),
    .b_i     ({1'b0, dvs_q}),
    .diff_o  (trial),
    .borrow_o(borrow)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`ifdef SEQ_DIV_EARLY_EXIT_EN
          else if (dividend < divisor) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = '0;
            rem_d   = dividend;
          end
`endif
          else begin
            r_d     = '0;
            q_d     = dividend;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        // No borrow: keep the difference and set the quotient bit;
        // borrow: restore the shifted remainder.
        r_d   = borrow ? r_sh : trial;
        q_d   = {q_sh[W-1:1], ~borrow};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          quo_d   = q_d;
          rem_d   = r_d[W-1:0];
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (W=4): directed cases,
// start-during-RUN, reset abort and a shuffled sweep of all operand pairs
// compared against plain integer division.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_restoring_divider #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: true when the operation bypasses RUN.
  function automatic bit skips_run(input int a, input int b);
`ifdef SEQ_DIV_EARLY_EXIT_EN
    return (b == 0) || (a < b);
`else
    return (b == 0);
`endif
  endfunction

  function automatic int ref_quo(input int a, input int b);
    return (b == 0) ? ((1 << W) - 1) : a / b;
  endfunction

  function automatic int ref_rem(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Issue one operation from IDLE and check latency, busy and results.
  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input int a, input int b, input string tag);
    int cyc;
    int exp_lat;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    exp_lat  = skips_run(a, b) ? 0 : W;
    check({tag, "_busy"}, 32'(busy), 32'(!skips_run(a, b)));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!done) check({tag, "_busy_run"}, 32'(busy), 32'(1));
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_quo"}, 32'(quotient), 32'(ref_quo(a, b)));
    check({tag, "_rem"}, 32'(remainder), 32'(ref_rem(a, b)));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(b == 0));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'(0));
    check({tag, "_hold"}, 32'({quotient, remainder}),
          32'((ref_quo(a, b) << W) | ref_rem(a, b)));
  endtask

  initial begin
    int order[256];
    int tmp;
    int j;
    int dones;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_quo", 32'(quotient), 32'(0));
    check("rst_rem", 32'(remainder), 32'(0));
    check("rst_dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(13, 3, "d13_3");
    run_op(15, 1, "d15_1");
    run_op(0, 7, "d0_7");
    run_op(9, 0, "d9_0");
    run_op(6, 2, "d6_2");

    // Start held/pulsed throughout a 14/5 operation with junk operands.
    start = 1'b1; dividend = 4'd14; divisor = 4'd5;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 0; i < W; i++) begin
      dividend = W'($urandom); divisor = W'($urandom);
      start = 1'(i % 2 == 0) | 1'b1;
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("s14_5_done", 32'(done), 32'(1));
    check("s14_5_quo", 32'(quotient), 32'(2));
    check("s14_5_rem", 32'(remainder), 32'(4));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("s14_5_single_done", 32'(dones), 32'(1));
    check("s14_5_idle", 32'(busy), 32'(0));

    // Reset during iteration 2 of 11/2.
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_pre", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_quo", 32'(quotient), 32'(0));
    check("abort_rem", 32'(remainder), 32'(0));
    check("abort_dbz", 32'(div_by_zero), 32'(0));
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'(0));
    run_op(11, 2, "d11_2");

    // Shuffled sweep of every operand pair.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(32'(i), 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      run_op(order[i] >> W, order[i] & ((1 << W) - 1), "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
